multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Moore-style FSM that sequences a shared-ALU, shared-memory multicycle MIPS datapath.
- Covers the same instruction subset as the single-cycle decoder: addu, subu, and, or, sltu, lw, sw, beq, addiu, j, ori, lui.
- Sits between the instruction register and datapath muxes/enables; talks to one unified memory port via a req/ready handshake.
- Traps on illegal opcodes, illegal funct codes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 255: max cycles a memory request may wait for mem_ready before trapping.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- instr  in  32  instruction register contents; stable from DECODE until the next FETCH completes
- zero  in  1  ALU zero flag, current cycle
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  request is a write (valid with mem_req)
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- irwrite  out  1  load instruction register
- pcwrite  out  1  load PC
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
- alusrca  out  1  ALU A: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B: 00 = rt, 01 = constant 4, 10 = extended imm, 11 = sign-ext imm<<2
- alucontrol  out  3  ALU op, same encoding as the decoder: 000 and, 001 or, 010 add, 011 ori, 100 lui, 110 sub, 111 sltu, 101 undefined
- regwrite  out  1  register file write
- destreg  out  5  register write index
- memtoreg  out  1  writeback from memory data
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  sticky trap flag
- state  out  4  current state code, for debug

Behaviour:
- Default for every output in every state is 0; alucontrol defaults to 010.
- While reset=1: state <= FETCH (0), illegal and timeout counter cleared, all outputs forced to 0, including mem_req.
- Reset mid-instruction abandons the instruction; mem_req drops in the same cycle reset is seen.
- State codes: FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, EXEC_I 7, ALUWB 8, BRANCH 9, JUMP 10, TRAP 15.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010.
  - If mem_ready: irwrite=1, pcwrite=1, pcsrc=00 in that cycle; go to DECODE.
  - Otherwise hold in FETCH.
- DECODE: alusrca=0, alusrcb=11, alucontrol=010 (branch target into ALUOut). Next state by op = instr[31:26]:
  - 000000 -> EXEC_R
  - 100011 or 101011 -> MEMADDR
  - 000100 -> BRANCH
  - 001001, 001101, 001111 -> EXEC_I
  - 000010 -> JUMP
  - any other op -> TRAP
- EXEC_R: alusrca=1, alusrcb=00. alucontrol from funct: 100001 -> 010, 100011 -> 110, 100100 -> 000, 100101 -> 001, 101011 -> 111.
  - Other funct: alucontrol=101, next state TRAP; no register write ever occurs.
  - Otherwise go to ALUWB.
- EXEC_I: alusrca=1, alusrcb=10. alucontrol: addiu 010, ori 011, lui 100. Go to ALUWB.
- ALUWB: regwrite=1, memtoreg=0, destreg = instr[15:11] if op=000000, else instr[20:16]. instr_done=1. Go to FETCH.
- MEMADDR: alusrca=1, alusrcb=10, alucontrol=010. Next state MEMWR if op[3]=1, else MEMRD.
- MEMRD: mem_req=1, iord=1. If mem_ready go to MEMWB, else hold.
- MEMWB: regwrite=1, memtoreg=1, destreg=instr[20:16], instr_done=1. Go to FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1. If mem_ready: instr_done=1 and go to FETCH; else hold.
- BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcwrite=zero, instr_done=1. Go to FETCH.
- JUMP: pcwrite=1, pcsrc=10, instr_done=1. Go to FETCH.
- TRAP: illegal<=1. All enables and mem_req are 0. Stay in TRAP until reset.
- Timeout counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle with mem_req=1 and mem_ready=0.
  - When the count equals MEM_TIMEOUT with mem_ready still 0, the next state is TRAP.
  - mem_ready in the same cycle as the limit wins (no trap).
- Zero-wait memory latencies, in cycles: R-type 4, I-type 4, lw 5, sw 4, beq 3, j 3.
- Each memory wait cycle adds 1 to the latency.

Test Plan:
- Reset then zero-wait memory, instr=addu $3,$1,$2 (0x00221821) -> states 0,1,6,8,0; ALUWB shows regwrite=1, destreg=3, alucontrol=010; instr_done pulses once in cycle 4.
- lw $5,4($4) (0x8C850004), mem_ready delayed 3 cycles in MEMRD -> MEMRD held 4 cycles; MEMWB shows regwrite=1, memtoreg=1, destreg=5; total 8 cycles.
- beq (0x10220003), once with zero=1 and once with zero=0 -> BRANCH shows pcsrc=01, pcwrite=1 and 0 respectively; 3 cycles each; no regwrite.
- sw (0xAC850008) -> MEMWR shows mem_req=1, mem_we=1, iord=1; regwrite never 1. Then instr=0xFC000000 -> TRAP, illegal=1 held for 20 cycles; reset clears it and the state returns to 0.
- R-type funct=000000 -> EXEC_R shows alucontrol=101, then TRAP; no regwrite at any point.
- Timeouts in FETCH: mem_ready held low with MEM_TIMEOUT=4 -> TRAP on cycle 6. mem_ready raised exactly on the limit cycle -> DECODE, no trap. Reset asserted during a MEMRD wait -> mem_req=0 in that cycle, state=0 next.

Source files
------------

// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
//
// Sequencing FSM for a multicycle MIPS datapath with one shared ALU and one
// unified memory port. It covers addu, subu, and, or, sltu, lw, sw, beq,
// addiu, ori, lui and j. It raises a sticky trap on an illegal opcode, an
// illegal R-type funct, or a memory request that waits too long for mem_ready.
//
// Parameters
//   MEM_TIMEOUT  limit for the memory wait counter (cycles)
//   TO_W         width of the wait counter, 2**TO_W > MEM_TIMEOUT
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   instr        instruction register contents
//   zero         ALU zero flag, current cycle
//   mem_ready    memory completes the current request this cycle
//   mem_req      memory request
//   mem_we       request is a write
//   iord         address select: 0 = PC, 1 = ALUOut
//   irwrite      load instruction register
//   pcwrite      load PC
//   pcsrc        PC source: 00 ALU result, 01 ALUOut, 10 jump target
//   alusrca      ALU A: 0 = PC, 1 = rs
//   alusrcb      ALU B: 00 rt, 01 const 4, 10 ext imm, 11 sext imm << 2
//   alucontrol   ALU operation
//   regwrite     register file write
//   destreg      register write index
//   memtoreg     writeback from memory data
//   instr_done   one-cycle pulse when an instruction retires
//   illegal      sticky trap flag
//   state        current state code (debug)
// ----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        irwrite,
    output logic        pcwrite,
    output logic [1:0]  pcsrc,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [2:0]  alucontrol,
    output logic        regwrite,
    output logic [4:0]  destreg,
    output logic        memtoreg,
    output logic        instr_done,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC_R  = 4'd6,
        S_EXEC_I  = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_TRAP    = 4'd15
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    // ALU operation encodings
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_ORI  = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b100;
    localparam logic [2:0] ALU_BAD  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    state_t          r_state;
    logic            r_illegal;
    logic [TO_W-1:0] r_to_cnt;

    state_t          w_next;
    logic [5:0]      w_op;
    logic [5:0]      w_funct;
    logic [4:0]      w_rt;
    logic [4:0]      w_rd;
    logic            w_funct_ok;
    logic [2:0]      w_r_alu;
    logic [2:0]      w_i_alu;
    logic            w_timeout;
    logic            w_unused;

    assign w_op      = instr[31:26];
    assign w_funct   = instr[5:0];
    assign w_rt      = instr[20:16];
    assign w_rd      = instr[15:11];
    // rs and shamt are datapath fields the controller never looks at.
    assign w_unused  = ^{instr[25:21], instr[10:6]};

    // Wait limit reached; only meaningful while a request is outstanding.
    assign w_timeout = (r_to_cnt == TO_LIMIT);

    // ------------------------------------------------------------------
    // Field decode shared by next-state and output logic
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_funct_ok = 1'b1;
        w_r_alu    = ALU_BAD;
        case (w_funct)
            FN_ADDU: w_r_alu = ALU_ADD;
            FN_SUBU: w_r_alu = ALU_SUB;
            FN_AND:  w_r_alu = ALU_AND;
            FN_OR:   w_r_alu = ALU_OR;
            FN_SLTU: w_r_alu = ALU_SLTU;
            default: w_funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_i_alu = ALU_ADD;
        case (w_op)
            OP_ORI:  w_i_alu = ALU_ORI;
            OP_LUI:  w_i_alu = ALU_LUI;
            default: w_i_alu = ALU_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                // A ready on the limit cycle completes the fetch.
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_DECODE: begin
                case (w_op)
                    OP_RTYPE:                 w_next = S_EXEC_R;
                    OP_LW, OP_SW:             w_next = S_MEMADDR;
                    OP_BEQ:                   w_next = S_BRANCH;
                    OP_ADDIU, OP_ORI, OP_LUI: w_next = S_EXEC_I;
                    OP_J:                     w_next = S_JUMP;
                    default:                  w_next = S_TRAP;
                endcase
            end
            // op[3] separates sw (101011) from lw (100011).
            S_MEMADDR: w_next = w_op[3] ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)      w_next = S_MEMWB;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_MEMWR: begin
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_EXEC_R:  w_next = w_funct_ok ? S_ALUWB : S_TRAP;
            S_EXEC_I:  w_next = S_ALUWB;
            S_ALUWB,
            S_MEMWB,
            S_BRANCH,
            S_JUMP:    w_next = S_FETCH;
            S_TRAP:    w_next = S_TRAP;
            // Unused codes are treated as corruption and trap.
            default:   w_next = S_TRAP;
        endcase
    end

    // ------------------------------------------------------------------
    // State, sticky trap flag and memory wait counter
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_state <= w_next;
            // Set alongside the TRAP entry so the flag and state agree.
            if (w_next == S_TRAP) begin
                r_illegal <= 1'b1;
            end
            // Any transition clears the counter, which covers every entry
            // into FETCH, MEMRD and MEMWR; it only counts while a request
            // stalls in place.
            if (w_next != r_state) begin
                r_to_cnt <= '0;
            end else if (mem_req && !mem_ready) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode. Outputs follow the state; the few same-cycle terms
    // (fetch completion, branch on zero, memory completion) use the
    // current inputs. Reset forces everything low at once so an
    // abandoned memory request drops immediately.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = ALU_ADD;
        regwrite   = 1'b0;
        destreg    = 5'd0;
        memtoreg   = 1'b0;
        instr_done = 1'b0;
        illegal    = r_illegal;
        state      = r_state;

        if (reset) begin
            alucontrol = 3'b000;
            illegal    = 1'b0;
            state      = 4'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = 2'b01;          // PC + 4
                    if (mem_ready) begin
                        irwrite = 1'b1;
                        pcwrite = 1'b1;
                    end
                end
                S_DECODE: begin
                    alusrcb = 2'b11;          // branch target into ALUOut
                end
                S_MEMADDR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    regwrite   = 1'b1;
                    memtoreg   = 1'b1;
                    destreg    = w_rt;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    mem_req    = 1'b1;
                    mem_we     = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC_R: begin
                    alusrca    = 1'b1;
                    alucontrol = w_r_alu;
                end
                S_EXEC_I: begin
                    alusrca    = 1'b1;
                    alusrcb    = 2'b10;
                    alucontrol = w_i_alu;
                end
                S_ALUWB: begin
                    regwrite   = 1'b1;
                    destreg    = (w_op == OP_RTYPE) ? w_rd : w_rt;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alusrca    = 1'b1;
                    alucontrol = ALU_SUB;
                    pcsrc      = 2'b01;
                    pcwrite    = zero;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pcwrite    = 1'b1;
                    pcsrc      = 2'b10;
                    instr_done = 1'b1;
                end
                default: begin
                    // TRAP and unused codes keep every enable low.
                end
            endcase
        end
    end

endmodule
